// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART core and its parallel shift-register
//   front ends (uart_sr_input / uart_sr_output).
//   - state_t            : transmit-side sequencer states
//   - DEFAULT_DATA_WIDTH : bits per character
//   - DEFAULT_BAUD_RATE  : line rate used by the uart core
//   - DEFAULT_CLK_FREQ   : system clock frequency in Hz
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_BAUD_RATE  = 115200;
    localparam int unsigned DEFAULT_CLK_FREQ   = 50_000_000;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PRESENT,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/uart_watchdog.sv
// ---------------------------------------------------------------------------
// uart_watchdog
//   Cycle counter that raises a single-cycle expire pulse once tick_i has been
//   seen LIMIT times since the last clear. The counter restarts from zero
//   after expiring, so it can be left running.
//   Ports:
//     clk      : system clock
//     rst_n    : asynchronous active-low reset
//     en_i     : global enable; low freezes the count
//     clear_i  : restart the count (wins over tick_i)
//     tick_i   : count this cycle
//     expire_o : high in the cycle whose tick completes LIMIT counts
// ---------------------------------------------------------------------------
module uart_watchdog #(
    parameter int unsigned LIMIT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          hit;

    // The tick that would take the count to LIMIT is the expiring one.
    assign hit      = tick_i && !clear_i && (count_q == LAST);
    assign expire_o = en_i && hit;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = hit ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_sr_output.sv
// ---------------------------------------------------------------------------
// uart_sr_output
//   On a start request, snapshots a CHARACTER_COUNT-character parallel buffer
//   and streams it, most-significant slot first, into the uart transmitter
//   over the tx_data/tx_valid/tx_ready handshake. A watchdog aborts the
//   message if the transmitter stops responding.
//   Ports:
//     clk      : system clock
//     reset_n  : asynchronous active-low reset
//     ena      : global enable; low freezes all state
//     sr_data  : message, slot k = sr_data[k*DATA_WIDTH +: DATA_WIDTH]
//     start    : request transmission (sampled in IDLE only)
//     tx_data  : character to uart
//     tx_valid : character valid to uart
//     tx_ready : uart ready; falls on accept, rises at end of frame
//     busy     : high whenever not IDLE
//     done     : one-cycle pulse after the last character completes
//     timeout  : one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module uart_sr_output
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int unsigned CHARACTER_COUNT = 10,
    parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ena,
    input  logic [DATA_WIDTH*CHARACTER_COUNT-1:0] sr_data,
    input  logic                                  start,
    output logic [DATA_WIDTH-1:0]                 tx_data,
    output logic                                  tx_valid,
    input  logic                                  tx_ready,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  timeout
);

    localparam int unsigned BUF_W = DATA_WIDTH * CHARACTER_COUNT;
    localparam int unsigned CL_W  = $clog2(CHARACTER_COUNT + 1);

    state_t                  state_q;
    logic [BUF_W-1:0]        buffer_q;
    logic [BUF_W-1:0]        buffer_shifted;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic                    tx_valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    timeout_q;
    logic [CL_W-1:0]         chars_left_q;

    logic wd_tick;
    logic wd_clear;
    logic wd_expire;

    // Next character is always the top slot once the sent one is shifted out.
    assign buffer_shifted = buffer_q << DATA_WIDTH;

    // The watchdog only runs while waiting on the transmitter. Seeing the
    // awaited tx_ready edge is the only non-abort way out of PRESENT/DRAIN,
    // so it doubles as the state-change clear.
    assign wd_tick  = (state_q == PRESENT) || (state_q == DRAIN);
    assign wd_clear = ((state_q == PRESENT) && !tx_ready) ||
                      ((state_q == DRAIN)   &&  tx_ready);

    uart_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (reset_n),
        .en_i     (ena),
        .clear_i  (wd_clear),
        .tick_i   (wd_tick),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            buffer_q     <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            chars_left_q <= '0;
        end else if (ena) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        buffer_q     <= sr_data;
                        chars_left_q <= CL_W'(CHARACTER_COUNT);
                        busy_q       <= 1'b1;
                        state_q      <= ARM;
                    end
                end
                // Do not present until a previous frame has fully drained.
                ARM: begin
                    if (tx_ready) begin
                        tx_data_q  <= buffer_q[BUF_W-1 -: DATA_WIDTH];
                        tx_valid_q <= 1'b1;
                        state_q    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (!tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= DRAIN;
                    end else if (wd_expire) begin
                        buffer_q     <= '0;
                        chars_left_q <= '0;
                        tx_valid_q   <= 1'b0;
                        busy_q       <= 1'b0;
                        timeout_q    <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                DRAIN: begin
                    if (tx_ready) begin
                        buffer_q     <= buffer_shifted;
                        chars_left_q <= chars_left_q - CL_W'(1);
                        if (chars_left_q == CL_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            tx_data_q  <= buffer_shifted[BUF_W-1 -: DATA_WIDTH];
                            tx_valid_q <= 1'b1;
                            state_q    <= PRESENT;
                        end
                    end else if (wd_expire) begin
                        buffer_q     <= '0;
                        chars_left_q <= '0;
                        tx_valid_q   <= 1'b0;
                        busy_q       <= 1'b0;
                        timeout_q    <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;

endmodule

// File: doc/uart_sr_output.md
Name: uart_sr_output

Overview:
- Transmit-side counterpart of the receive shift register (`uart_sr_input`).
- On a start pulse, snapshots a CHARACTER_COUNT-character parallel buffer and streams it byte by byte into the `uart` transmitter over the tx_data/tx_valid/tx_ready handshake.
- Oldest character goes first: most-significant slot first. A loopback through `uart` and `uart_sr_input` therefore reproduces the buffer exactly.
- Sits between design logic (e.g. a message ROM or register bank) and the `uart` core.

Parameters:
- DATA_WIDTH, 8, bits per character.
- CHARACTER_COUNT, 10, characters per message.
- TIMEOUT_CYCLES, 100000, cycles allowed in PRESENT or DRAIN without the expected tx_ready edge before abort.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; low freezes all state.
- sr_data  input  DATA_WIDTH*CHARACTER_COUNT  message; slot k = sr_data[k*DATA_WIDTH +: DATA_WIDTH]; slot CHARACTER_COUNT-1 is sent first.
- start  input  1  request transmission; sampled only in IDLE.
- tx_data  output  DATA_WIDTH  character to `uart`.
- tx_valid  output  1  character valid to `uart`.
- tx_ready  input  1  `uart` idle/ready; falls when a character is accepted, rises when its frame completes.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last character completes.
- timeout  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - state = IDLE.
  - buffer = 0, tx_data = 0.
  - tx_valid = busy = done = timeout = 0.
  - chars_left = 0, watchdog = 0.
- All outputs are decoded from registers only; no combinational path from inputs to outputs.
- State machine (all transitions at posedge clk, only when ena = 1):
  - IDLE: when start = 1, load buffer <= sr_data, chars_left <= CHARACTER_COUNT, go to ARM. start in any other state is ignored (no queuing).
  - ARM: wait for tx_ready = 1, then go to PRESENT. This guards against a transmitter already busy from a prior frame. No timeout in ARM.
  - PRESENT: tx_valid = 1, tx_data = buffer top slot. When tx_ready = 0 is sampled (character accepted), go to DRAIN.
  - DRAIN: tx_valid = 0. When tx_ready = 1 is sampled:
    - shift buffer left by DATA_WIDTH (zero fill);
    - decrement chars_left;
    - if chars_left was 1, go to DONE; otherwise go to PRESENT.
  - DONE: done = 1 for exactly one cycle, then IDLE. busy stays high during DONE.
- Watchdog:
  - Counts cycles spent in PRESENT or DRAIN; cleared on every state change.
  - On reaching TIMEOUT_CYCLES: pulse timeout for one cycle, clear buffer, go to IDLE.
  - done is not asserted on timeout.
- ena = 0: state, buffer, counters and outputs hold their values; tx_valid holds too. A start seen while ena = 0 is lost.
- sr_data changes after the start sample have no effect on the message in flight.
- start held high continuously: a new message begins on the first IDLE cycle after DONE, i.e. back-to-back messages with one IDLE cycle between them.
- Latency, with tx_ready already high: start sampled at edge N → ARM after N → PRESENT after N+1 → tx_valid high in the cycle following edge N+1.
- Reset mid-message: immediate return to IDLE with tx_valid = 0. The `uart` may finish the current frame; no further characters are sent.
- Width rules:
  - chars_left width = $clog2(CHARACTER_COUNT+1).
  - watchdog width = $clog2(TIMEOUT_CYCLES+1).
  - CHARACTER_COUNT = 1 is legal: a single PRESENT/DRAIN pass.

Decomposition:
- Shared package `uart_pkg`:
  - enum state_t {IDLE, ARM, PRESENT, DRAIN, DONE};
  - default DATA_WIDTH, BAUD_RATE, CLK_FREQ constants shared with `uart` and `uart_sr_input`.
- One natural sub-module: `uart_watchdog`, a parameterised cycle counter with clear, enable and expire-pulse. It is reusable by benches and the receive path.
- The FSM and the buffer shifter remain in `uart_sr_output`.

Test Plan:
- Loopback `uart_sr_output` → `uart` (115200 baud, 50 MHz) → `uart_sr_input`, sr_data = "0123456789" (0x30..0x39, 0x30 in slot 9), pulse start → receiver sr_data equals 0x30..0x39 in the same slots; exactly one done pulse; busy low afterwards; timeout never asserted.
- tx_ready held low for 500 cycles before start → block stays in ARM; tx_valid stays 0 until tx_ready rises; then first byte 0x30 is presented.
- Change sr_data to all 0xFF one cycle after start → transmitted bytes are still 0x30..0x39.
- Stub `uart` that never drops tx_ready, TIMEOUT_CYCLES = 50 → timeout pulses 50 cycles after entering PRESENT; done = 0; busy = 0 on the next cycle.
- ena deasserted for 1000 cycles mid-message (in DRAIN) → state and tx_data frozen; transmission resumes on ena = 1 and the received sequence is still complete.
- reset_n pulsed low while the 4th character is in PRESENT → tx_valid = 0 and busy = 0 within the same cycle (asynchronous); a subsequent start sends a full 10-character message.
